nios2_debug_scan_master: RTL and testbench
==========================================

Name: nios2_debug_scan_master

Overview:
- Host-side initiator for the CPU's 2-bit-IR / 38-bit-DR virtual-JTAG debug interface.
- Accepts scan commands (IR value plus 38-bit DR payload) and drives vji_tck, vji_tdi, vji_ir_in and the virtual-state strobes through a complete UIR->CDR->SDR->UDR sequence.
- Captures vji_tdo and vji_ir_out, then returns them as a response.
- Serves as the on-chip debug host and as the bench driver for the debug slave.

Parameters:
- DR_WIDTH, 38, scan-chain length in bits.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per tck half-period; minimum 1, and 0 is illegal.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_ir  in  IR_WIDTH  virtual IR value for this scan
- cmd_data  in  DR_WIDTH  DR bits shifted out, LSB first
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  DR_WIDTH  bits captured from vji_tdo, LSB = first captured
- rsp_ir  out  IR_WIDTH  vji_ir_out sampled during CDR
- vji_tck  out  1  generated test clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  IR_WIDTH  virtual IR to slave
- vji_ir_out  in  IR_WIDTH  status IR from slave
- vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual JTAG state indicators
- busy  out  1  high from command accept until the response is accepted

Behaviour:
- Reset values:
  - state IDLE; cmd_ready=1; rsp_valid=0.
  - rsp_data=0, rsp_ir=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - vji_rti=1; vji_uir, vji_cdr, vji_sdr, vji_udr all 0.
  - busy=0.
- Reset mid-operation: the scan is abandoned, any pending response is discarded, and all outputs return to reset values on the next clk.
- States: IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
- One tck period is 2*TCK_DIV clk cycles:
  - tck is low for the first TCK_DIV cycles and high for the last TCK_DIV cycles.
  - State strobes and tdi change only at the start of a period, i.e. the tck falling edge.
- IDLE:
  - cmd_ready=1, vji_rti=1.
  - On accept, latch cmd_ir into vji_ir_in and cmd_data into the shift register, then enter UIR on the next clk.
- UIR: one tck period, vji_uir=1. vji_ir_in holds cmd_ir from UIR until the next command is accepted.
- CDR: one tck period, vji_cdr=1. On the clk where tck rises, latch vji_ir_out into rsp_ir.
- SDR: DR_WIDTH tck periods, vji_sdr=1.
  - vji_tdi = shift register bit 0.
  - On each tck rising clk, sample vji_tdo into capture bit DR_WIDTH-1, shift the capture register right, and shift the tx register right.
  - After DR_WIDTH periods, capture bit 0 holds the first sampled tdo.
  - Bit counter width is clog2(DR_WIDTH+1); the exit condition is count==DR_WIDTH-1 at the period end.
- UDR: one tck period, vji_udr=1, tdi=0.
- RTI: one tck period, vji_rti=1. This gives the slave time to synchronise UDR into the system clock domain.
- RESP:
  - tck held 0; rsp_valid=1, with rsp_data and rsp_ir stable.
  - Holds until rsp_ready, then returns to IDLE on the next clk.
  - If rsp_ready is already high on the first RESP cycle, the response lasts exactly one cycle.
- Handshake rules:
  - cmd_ready=0 outside IDLE, so the next command can be accepted no earlier than the cycle after the response handshake.
  - busy = !(state==IDLE).
- Latency:
  - Command accepted at cycle T -> rsp_valid first high at T+1+(DR_WIDTH+4)*2*TCK_DIV.
  - Defaults: T+169.
  - vji_sdr is high for DR_WIDTH*2*TCK_DIV = 152 consecutive clk cycles.
- Input handling: no tdo synchronisation is performed (same clock domain). cmd_valid asserted while not ready is ignored with no side effect.

Test Plan:
- Loopback (vji_tdo=vji_tdi), cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A, vji_ir_in=2'b01, rsp_valid first high 169 clk after accept.
- vji_tdo tied 1, vji_ir_out=2'b10, cmd_data=0 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir=2'b10; vji_sdr high exactly 152 consecutive cycles; uir, cdr and udr each high exactly 4 cycles, in order.
- tdo driven by the bench as 1 only on the 1st tck rising edge -> rsp_data=38'h00_0000_0001; with the 1 only on the 38th edge -> 38'h20_0000_0000.
- rsp_ready held low 20 cycles after rsp_valid, with a second command offered -> rsp_valid and data stable, cmd_ready=0, no tck activity; after the handshake, cmd_ready=1 on the next cycle and the second scan starts.
- reset pulsed for 1 cycle mid-SDR (bit 17) -> next cycle: tck=0, sdr=0, rti=1, cmd_ready=1, rsp_valid=0; a following loopback scan returns correct data.
- TCK_DIV=1 build, loopback cmd_data=38'h15_5555_5555 -> tck period 2 clk, rsp_valid at T+85, data matches.

Source files
------------

// File: rtl/nios2_debug_scan_master_if.sv
// Command/response channel between a debug host client and the scan master.
// The scan master takes the slave side: it receives commands and returns responses.
interface nios2_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir
    );
endinterface

// File: rtl/nios2_debug_scan_master.sv
// Virtual-JTAG scan initiator: runs one UIR->CDR->SDR->UDR->RTI sequence per
// command and returns the captured DR bits and the status IR.
module nios2_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    nios2_debug_scan_master_if.slave bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                busy
);
    localparam int PERIOD = 2 * TCK_DIV;
    localparam int DIV_W  = $clog2(PERIOD);
    localparam int CNT_W  = $clog2(DR_WIDTH + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UIR  = 3'd1;
    localparam logic [2:0] S_CDR  = 3'd2;
    localparam logic [2:0] S_SDR  = 3'd3;
    localparam logic [2:0] S_UDR  = 3'd4;
    localparam logic [2:0] S_RTI  = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]          state;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DR_WIDTH-1:0] tx_sr;
    logic [DR_WIDTH-1:0] cap_sr;
    logic [IR_WIDTH-1:0] ir_cap;
    logic                scanning;
    logic                rise_edge;
    logic                period_end;

    always_comb begin
        scanning   = (state == S_UIR) || (state == S_CDR) || (state == S_SDR) ||
                     (state == S_UDR) || (state == S_RTI);
        rise_edge  = scanning && (div_cnt == DIV_W'(TCK_DIV - 1));
        period_end = scanning && (div_cnt == DIV_W'(PERIOD - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            cap_sr    <= '0;
            ir_cap    <= '0;
            vji_ir_in <= '0;
        end else begin
            if (scanning && !period_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        vji_ir_in <= bus.cmd_ir;
                        tx_sr     <= bus.cmd_data;
                        state     <= S_UIR;
                    end
                end
                S_UIR: begin
                    if (period_end) state <= S_CDR;
                end
                S_CDR: begin
                    if (rise_edge) ir_cap <= vji_ir_out;
                    if (period_end) begin
                        bit_cnt <= '0;
                        state   <= S_SDR;
                    end
                end
                S_SDR: begin
                    if (rise_edge) cap_sr <= {vji_tdo, cap_sr[DR_WIDTH-1:1]};
                    // tx advances at the period end so tdi only moves on the tck falling edge
                    if (period_end) begin
                        tx_sr <= {1'b0, tx_sr[DR_WIDTH-1:1]};
                        if (bit_cnt == CNT_W'(DR_WIDTH - 1)) begin
                            state <= S_UDR;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_UDR: begin
                    if (period_end) state <= S_RTI;
                end
                S_RTI: begin
                    if (period_end) state <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        vji_tck       = scanning && (div_cnt >= DIV_W'(TCK_DIV));
        vji_tdi       = (state == S_SDR) && tx_sr[0];
        vji_rti       = (state == S_IDLE) || (state == S_RTI) || (state == S_RESP);
        vji_uir       = (state == S_UIR);
        vji_cdr       = (state == S_CDR);
        vji_sdr       = (state == S_SDR);
        vji_udr       = (state == S_UDR);
        busy          = (state != S_IDLE);
        bus.cmd_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_data  = cap_sr;
        bus.rsp_ir    = ir_cap;
    end
endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// Scoreboard bench for the scan master: a driver queues expected responses,
// a monitor checks them, and a small second instance covers the fastest tck.
module tb_nios2_debug_scan_master;
    localparam int DR   = 38;
    localparam int IR   = 2;
    localparam int DIV  = 2;
    localparam int LAT  = 1 + (DR + 4) * 2 * DIV;
    localparam int LAT1 = 1 + (DR + 4) * 2;

    typedef struct {
        logic [DR-1:0] data;
        logic [IR-1:0] ir;
        logic [IR-1:0] rir;
        longint        acc;
        int            stall;
    } exp_t;

    typedef struct {
        bit            loop;
        logic [DR-1:0] pat;
        logic [IR-1:0] irout;
    } cfg_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // main instance
    nios2_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus ();
    logic tck, tdi, tdo, rti, uir, cdr, sdr, udr, busy;
    logic [IR-1:0] ir_in, ir_out;

    nios2_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
        .vji_ir_in(ir_in), .vji_ir_out(ir_out),
        .vji_rti(rti), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr),
        .busy(busy)
    );

    // fastest-tck instance, loopback wired
    nios2_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus1 ();
    logic tck1, tdi1, rti1, uir1, cdr1, sdr1, udr1, busy1;
    logic [IR-1:0] ir_in1;
    logic [IR-1:0] ir_out1 = 2'b11;

    nios2_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdi1),
        .vji_ir_in(ir_in1), .vji_ir_out(ir_out1),
        .vji_rti(rti1), .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1),
        .busy(busy1)
    );

    exp_t exp_q[$];
    cfg_t cfg_q[$];

    // slave model: per-scan tdo source chosen when UIR begins
    cfg_t cur_cfg;
    int   tcnt = 0;
    logic prev_tck = 1'b0;
    logic prev_uir = 1'b0;

    always @(negedge clk) begin
        if (uir === 1'b1 && prev_uir !== 1'b1) begin
            tcnt = 0;
            if (cfg_q.size() > 0) begin
                cur_cfg = cfg_q.pop_front();
            end else begin
                tests++;
                fails++;
                $display("FAIL scan_start: scan began with no command queued (cycle %0d)", cyc);
            end
        end else if (sdr === 1'b1 && tck === 1'b1 && prev_tck !== 1'b1) begin
            tcnt++;
        end
        prev_tck = tck;
        prev_uir = uir;
    end

    always_comb begin
        tdo = 1'b0;
        if (cur_cfg.loop) tdo = tdi;
        else if (tcnt < DR) tdo = cur_cfg.pat[tcnt[5:0]];
    end
    assign ir_out = cur_cfg.irout;

    // strobe shape of the current scan, cleared whenever the master is idle
    int     n_uir, n_cdr, n_sdr, n_udr, n_rti, n_tck;
    longint f_uir, f_cdr, f_sdr, f_udr;

    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_tck = 0;
            f_uir = 0; f_cdr = 0; f_sdr = 0; f_udr = 0;
        end else begin
            if (uir === 1'b1) begin if (n_uir == 0) f_uir = cyc; n_uir++; end
            if (cdr === 1'b1) begin if (n_cdr == 0) f_cdr = cyc; n_cdr++; end
            if (sdr === 1'b1) begin if (n_sdr == 0) f_sdr = cyc; n_sdr++; end
            if (udr === 1'b1) begin if (n_udr == 0) f_udr = cyc; n_udr++; end
            if (rti === 1'b1 && bus.rsp_valid !== 1'b1) n_rti++;
            if (tck === 1'b1) n_tck++;
        end
    end

    // response monitor; owns rsp_ready
    exp_t   cur;
    bit     in_rsp = 1'b0;
    bit     have_cur = 1'b0;
    int     hold = 0;
    int     rlen = 0;
    longint hs_cyc = 0;

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                exp_q.delete();
                in_rsp = 1'b0;
                bus.rsp_ready = 1'b1;
            end else if (bus.rsp_valid === 1'b1) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    rlen   = 0;
                    hold   = 0;
                    have_cur = (exp_q.size() > 0);
                    if (!have_cur) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: response with empty scoreboard (cycle %0d)", cyc);
                    end else begin
                        cur  = exp_q.pop_front();
                        hold = cur.stall;
                        check("rsp_data", 64'(bus.rsp_data), 64'(cur.data));
                        check("rsp_ir", 64'(bus.rsp_ir), 64'(cur.rir));
                        check("ir_in", 64'(ir_in), 64'(cur.ir));
                        check("latency", 64'(cyc - cur.acc), 64'(LAT));
                        check("uir_len", 64'(n_uir), 64'(2 * DIV));
                        check("cdr_len", 64'(n_cdr), 64'(2 * DIV));
                        check("sdr_len", 64'(n_sdr), 64'(DR * 2 * DIV));
                        check("udr_len", 64'(n_udr), 64'(2 * DIV));
                        check("rti_len", 64'(n_rti), 64'(2 * DIV));
                        check("tck_high", 64'(n_tck), 64'((DR + 4) * DIV));
                        check("cdr_after_uir", 64'(f_cdr - f_uir), 64'(2 * DIV));
                        check("sdr_after_cdr", 64'(f_sdr - f_cdr), 64'(2 * DIV));
                        check("udr_after_sdr", 64'(f_udr - f_sdr), 64'(DR * 2 * DIV));
                    end
                end else if (have_cur) begin
                    check("stall_data", 64'(bus.rsp_data), 64'(cur.data));
                    check("stall_cmd_ready", 64'(bus.cmd_ready), 64'(0));
                    check("stall_tck", 64'(tck), 64'(0));
                end
                rlen++;
                if (hold > 0) begin
                    bus.rsp_ready = 1'b0;
                    hold--;
                end else begin
                    bus.rsp_ready = 1'b1;
                    hs_cyc = cyc;
                end
            end else if (in_rsp) begin
                in_rsp = 1'b0;
                if (have_cur) check("rsp_len", 64'(rlen), 64'(cur.stall + 1));
                check("cmd_ready_after_rsp", 64'(bus.cmd_ready), 64'(1));
            end
        end
    end

    longint last_acc = 0;

    task automatic send(input logic [IR-1:0] ir, input logic [DR-1:0] data, input bit loop,
                        input logic [DR-1:0] pat, input logic [IR-1:0] irout, input int stall);
        exp_t e;
        cfg_t c;
        int   w;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = ir;
        bus.cmd_data  = data;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept_timeout: cmd_ready never rose (cycle %0d)", cyc);
            bus.cmd_valid = 1'b0;
            return;
        end
        c.loop  = loop;
        c.pat   = pat;
        c.irout = irout;
        cfg_q.push_back(c);
        e.data  = loop ? data : pat;
        e.ir    = ir;
        e.rir   = irout;
        e.acc   = cyc;
        e.stall = stall;
        exp_q.push_back(e);
        last_acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~data;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() > 0 || busy !== 1'b0) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0 || busy !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, busy=%b", exp_q.size(), busy);
        end
    endtask

    initial begin
        logic [63:0]   r;
        logic [DR-1:0] d, p;
        logic [DR-1:0] one_val;
        longint        t0, t_rsp, rise0, rise1;
        int            w;
        bit            got;

        reset = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_ir     = '0;
        bus.cmd_data   = '0;
        bus1.cmd_valid = 1'b0;
        bus1.cmd_ir    = '0;
        bus1.cmd_data  = '0;
        bus1.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        check("rst_rsp_ir", 64'(bus.rsp_ir), 64'(0));
        check("rst_tck_tdi_irin", 64'({tck, tdi, ir_in}), 64'(0));
        check("rst_strobes", 64'({rti, uir, cdr, sdr, udr}), 64'(5'b10000));
        check("rst_busy", 64'(busy), 64'(0));

        send(2'b01, 38'h2A_5A5A_5A5A, 1'b1, '0, 2'b00, 0);
        send(2'b11, '0, 1'b0, '1, 2'b10, 0);
        one_val = 38'h1;
        send(2'b00, 38'h12_3456_789A, 1'b0, one_val, 2'b01, 1);
        one_val = 38'h20_0000_0000;
        send(2'b10, 38'h0F_0F0F_0F0F, 1'b0, one_val, 2'b11, 0);
        drain();

        // long stall with a second command waiting behind it
        send(2'b10, 38'h33_CCCC_3333, 1'b1, '0, 2'b01, 20);
        send(2'b01, 38'h0C_3333_CCCC, 1'b1, '0, 2'b10, 0);
        check("accept_after_handshake", 64'(last_acc), 64'(hs_cyc + 1));
        drain();

        // reset during the 18th shift period abandons the scan
        send(2'b11, 38'h1F_0000_FFFF, 1'b1, '0, 2'b01, 0);
        w = 0;
        while (!(sdr === 1'b1 && tcnt == 17) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("reach_bit17", 64'(tcnt), 64'(17));
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tck_sdr", 64'({tck, sdr}), 64'(0));
        check("midrst_rti", 64'(rti), 64'(1));
        check("midrst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        send(2'b01, 38'h2B_DEAD_BEEF, 1'b1, '0, 2'b10, 0);
        drain();

        for (int i = 0; i < 16; i++) begin
            r = {$urandom(), $urandom()};
            d = r[DR-1:0];
            r = {$urandom(), $urandom()};
            p = r[DR-1:0];
            send(IR'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)), p,
                 IR'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        drain();

        // fastest tck: 2-clk period, loopback
        @(negedge clk);
        check("div1_cmd_ready", 64'(bus1.cmd_ready), 64'(1));
        bus1.cmd_valid = 1'b1;
        bus1.cmd_ir    = 2'b10;
        bus1.cmd_data  = 38'h15_5555_5555;
        t0 = cyc;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        rise0 = -1;
        rise1 = -1;
        got = 1'b0;
        t_rsp = 0;
        w = 0;
        while (!got && w < 500) begin
            if (tck1 === 1'b1 && rise0 < 0) rise0 = cyc;
            else if (tck1 === 1'b1 && rise1 < 0 && cyc > rise0 + 1) rise1 = cyc;
            if (bus1.rsp_valid === 1'b1) begin
                got = 1'b1;
                t_rsp = cyc;
                check("div1_rsp_data", 64'(bus1.rsp_data), 64'(38'h15_5555_5555));
                check("div1_rsp_ir", 64'(bus1.rsp_ir), 64'(2'b11));
                check("div1_ir_in", 64'(ir_in1), 64'(2'b10));
            end else begin
                @(negedge clk);
                w++;
            end
        end
        check("div1_rsp_seen", 64'(got), 64'(1));
        check("div1_latency", 64'(t_rsp - t0), 64'(LAT1));
        check("div1_tck_period", 64'(rise1 - rise0), 64'(2));
        repeat (3) @(negedge clk);
        check("div1_idle", 64'(busy1), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
